// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for the N:1 stream multiplexer: N producer lanes in, one consumer lane out.
// The slave modport is the multiplexer's view and the master modport is the surrounding datapath's view.
interface stream_mux_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a built-in round-robin or fixed-priority arbiter
// and a one-deep registered output stage (one cycle latency, one beat per cycle).
module stream_mux_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [SELW-1:0]  ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_sel_reg;

  logic             load;
  logic [SELW-1:0]  search_start;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant;
  logic [N-1:0]     fire_vec;
  logic             fire;
  logic [WIDTH-1:0] data_next;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] ch_data [N];

  // The output register can take a new beat when empty or when its beat leaves this cycle.
  assign load = ~out_valid_reg | bus.out_ready;

  assign search_start = (MODE == 0) ? ptr_reg : '0;

  // Cyclic search from search_start; the index is folded back below N so that
  // non-power-of-two channel counts never select a nonexistent lane.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < N; j++) begin
      idx = int'(search_start) + j;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!grant_found && bus.in_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SELW'(idx);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]  = bus.in_data[gi*WIDTH +: WIDTH];
      assign grant[gi]    = grant_found && (grant_idx == SELW'(gi));
      assign bus.in_ready[gi] = load & grant[gi] & rst_n;
      assign fire_vec[gi] = bus.in_valid[gi] & bus.in_ready[gi];
    end
  endgenerate

  assign fire = |fire_vec;

  always_comb begin
    data_next = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        data_next = data_next | ch_data[i];
      end
    end
  end

  assign ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= data_next;
      out_sel_reg   <= grant_idx;
      if (MODE == 0) begin
        ptr_reg <= ptr_next;
      end
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;
endmodule
